// File: rtl/mmu_tlb_pkg.sv
// Shared definitions for the mmu_tlb address-translation unit.
// Holds the FSM state type, PTE field positions and the derived page-number width.
package mmu_tlb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLookup,
    StWalk,
    StResp
  } state_e;

  localparam int unsigned PteW        = 32;
  localparam int unsigned PteValidBit = 0;

  // VPN and PPN share one width: the word address minus the in-page offset.
  function automatic int unsigned vpn_width(input int unsigned aw, input int unsigned off_w);
    return aw - off_w;
  endfunction

  // The PPN occupies the top ppn_w bits of the PTE.
  function automatic int unsigned pte_ppn_lsb(input int unsigned ppn_w);
    return PteW - ppn_w;
  endfunction

endpackage

// File: rtl/mmu_tlb_cam.sv
// Fully-associative TLB storage with round-robin replacement.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   lookup_vpn             tag to match (combinational)
//   hit, hit_ppn           match result
//   wr_en, wr_vpn, wr_ppn  install at the round-robin pointer, then advance it
//   flush                  clear all valid bits (wins over a same-cycle install)
module mmu_tlb_cam #(
  parameter int unsigned TLB_N = 4,
  parameter int unsigned VPN_W = 20,
  parameter int unsigned PPN_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [VPN_W-1:0] lookup_vpn,
  output logic             hit,
  output logic [PPN_W-1:0] hit_ppn,
  input  logic             wr_en,
  input  logic [VPN_W-1:0] wr_vpn,
  input  logic [PPN_W-1:0] wr_ppn,
  input  logic             flush
);

  localparam int unsigned PtrW = $clog2(TLB_N);

  logic [TLB_N-1:0] valid_q;
  logic [VPN_W-1:0] vpn_q [TLB_N];
  logic [PPN_W-1:0] ppn_q [TLB_N];
  logic [PtrW-1:0]  ptr_q;

  // At most one entry can match, so a priority-free select is enough.
  always_comb begin
    hit     = 1'b0;
    hit_ppn = '0;
    for (int i = 0; i < TLB_N; i++) begin
      if (valid_q[i] && (vpn_q[i] == lookup_vpn)) begin
        hit     = 1'b1;
        hit_ppn = ppn_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      ptr_q   <= '0;
    end else begin
      if (wr_en) begin
        valid_q[ptr_q] <= 1'b1;
        ptr_q          <= ptr_q + PtrW'(1);
      end
      if (flush) begin
        valid_q <= '0;
      end
    end
  end

  // Tag and data arrays need no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      vpn_q[ptr_q] <= wr_vpn;
      ppn_q[ptr_q] <= wr_ppn;
    end
  end

endmodule

// File: rtl/mmu_tlb.sv
// Address-translation unit: request latch, TLB lookup and single-level page-table walker.
// Ports:
//   req_valid/req_ready         request handshake (ready only when idle)
//   req_e, req_pc, req_ea       source select and candidate word addresses
//   mode, pto                   translate enable and page-table origin, latched on accept
//   flush                       invalidate the whole TLB
//   resp_valid/ma/fault         one-cycle response; ma/fault hold until the next response
//   mem_req/addr, mem_ack/rdata PTE read handshake
module mmu_tlb
  import mmu_tlb_pkg::*;
#(
  parameter int unsigned AW    = 30,
  parameter int unsigned OFF_W = 10,
  parameter int unsigned TLB_N = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_e,
  input  logic [AW-1:0] req_pc,
  input  logic [AW-1:0] req_ea,
  input  logic          mode,
  input  logic [AW-1:0] pto,
  input  logic          flush,
  output logic          resp_valid,
  output logic [AW-1:0] resp_ma,
  output logic          resp_fault,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [31:0]   mem_rdata
);

  localparam int unsigned VPN_W  = vpn_width(AW, OFF_W);
  localparam int unsigned PPN_W  = VPN_W;
  localparam int unsigned PpnLsb = pte_ppn_lsb(PPN_W);

  state_e           state_q, state_d;
  logic [AW-1:0]    va_q, pto_q;
  logic             mode_q;
  logic             flush_seen_q;
  logic [AW-1:0]    resp_ma_q, resp_ma_d;
  logic             resp_fault_q, resp_fault_d;

  logic             accept;
  logic [VPN_W-1:0] vpn;
  logic [OFF_W-1:0] off;
  logic [PPN_W-1:0] pte_ppn;
  logic             pte_valid;
  logic             cam_hit;
  logic [PPN_W-1:0] cam_ppn;
  logic             wr_en;
  logic             unused_pte;

  assign accept     = req_valid && (state_q == StIdle);
  assign vpn        = va_q[AW-1:OFF_W];
  assign off        = va_q[OFF_W-1:0];
  assign pte_ppn    = mem_rdata[PteW-1:PpnLsb];
  assign pte_valid  = mem_rdata[PteValidBit];
  assign unused_pte = ^mem_rdata[PpnLsb-1:PteValidBit+1];

  mmu_tlb_cam #(
    .TLB_N (TLB_N),
    .VPN_W (VPN_W),
    .PPN_W (PPN_W)
  ) u_cam (
    .clk        (clk),
    .rst_n      (rst_n),
    .lookup_vpn (vpn),
    .hit        (cam_hit),
    .hit_ppn    (cam_ppn),
    .wr_en      (wr_en),
    .wr_vpn     (vpn),
    .wr_ppn     (pte_ppn),
    .flush      (flush)
  );

  always_comb begin
    state_d      = state_q;
    resp_ma_d    = resp_ma_q;
    resp_fault_d = resp_fault_q;
    wr_en        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) state_d = StLookup;
      end
      StLookup: begin
        if (!mode_q) begin
          resp_ma_d    = va_q;
          resp_fault_d = 1'b0;
          state_d      = StResp;
        end else if (cam_hit && !flush) begin
          // A same-cycle flush turns a hit into a miss.
          resp_ma_d    = {cam_ppn, off};
          resp_fault_d = 1'b0;
          state_d      = StResp;
        end else begin
          state_d = StWalk;
        end
      end
      StWalk: begin
        if (mem_ack) begin
          state_d = StResp;
          if (pte_valid) begin
            resp_ma_d    = {pte_ppn, off};
            resp_fault_d = 1'b0;
            // Any flush seen during this walk makes the walked entry stale.
            wr_en        = !flush && !flush_seen_q;
          end else begin
            resp_ma_d    = va_q;
            resp_fault_d = 1'b1;
          end
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      va_q         <= '0;
      pto_q        <= '0;
      mode_q       <= 1'b0;
      flush_seen_q <= 1'b0;
      resp_ma_q    <= '0;
      resp_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      resp_ma_q    <= resp_ma_d;
      resp_fault_q <= resp_fault_d;
      if (accept) begin
        va_q         <= req_e ? req_ea : req_pc;
        pto_q        <= pto;
        mode_q       <= mode;
        flush_seen_q <= 1'b0;
      end else if ((state_q == StWalk) && flush) begin
        flush_seen_q <= 1'b1;
      end
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_ma    = resp_ma_q;
  assign resp_fault = resp_fault_q;
  assign mem_req    = (state_q == StWalk);
  assign mem_addr   = pto_q + AW'(vpn);

endmodule

// File: tb/tb_mmu_tlb.sv
module tb_mmu_tlb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_e = 1'b0;
  logic [29:0] req_pc = '0;
  logic [29:0] req_ea = '0;
  logic        mode = 1'b0;
  logic [29:0] pto = '0;
  logic        flush = 1'b0;
  logic        resp_valid;
  logic [29:0] resp_ma;
  logic        resp_fault;
  logic        mem_req;
  logic [29:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  mmu_tlb #(
    .AW    (30),
    .OFF_W (10),
    .TLB_N (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_e      (req_e),
    .req_pc     (req_pc),
    .req_ea     (req_ea),
    .mode       (mode),
    .pto        (pto),
    .flush      (flush),
    .resp_valid (resp_valid),
    .resp_ma    (resp_ma),
    .resp_fault (resp_fault),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Expected outputs for the cycle after the most recent rising edge.
  bit          chk_en = 1'b0;
  bit          exp_ready = 1'b1;
  bit          exp_mem_req = 1'b0;
  logic [29:0] exp_mem_addr = '0;
  bit          exp_resp_valid = 1'b0;
  logic [29:0] exp_ma = '0;
  bit          exp_fault = 1'b0;

  // Translation model: four slots replaced in round-robin order.
  bit          m_valid [4];
  logic [19:0] m_vpn   [4];
  logic [19:0] m_ppn   [4];
  int          m_ptr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_lookup(input logic [19:0] v, output logic [19:0] p);
    p = '0;
    for (int i = 0; i < 4; i++) begin
      if (m_valid[i] && m_vpn[i] == v) begin
        p = m_ppn[i];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic m_install(input logic [19:0] v, input logic [19:0] p);
    m_valid[m_ptr] = 1'b1;
    m_vpn[m_ptr]   = v;
    m_ppn[m_ptr]   = p;
    m_ptr          = (m_ptr + 1) % 4;
  endtask

  task automatic m_flush();
    for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
  endtask

  task automatic m_reset();
    m_flush();
    m_ptr = 0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", {31'b0, req_ready}, {31'b0, exp_ready});
      chk("mem_req", {31'b0, mem_req}, {31'b0, exp_mem_req});
      chk("resp_valid", {31'b0, resp_valid}, {31'b0, exp_resp_valid});
      if (exp_mem_req) chk("mem_addr", {2'b0, mem_addr}, {2'b0, exp_mem_addr});
      chk("resp_ma", {2'b0, resp_ma}, {2'b0, exp_ma});
      chk("resp_fault", {31'b0, resp_fault}, {31'b0, exp_fault});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // fl: 0 none, 1 flush during LOOKUP, 2 flush on first WALK cycle (needs d>=1), 3 flush with ack
  task automatic xact(input bit e, input logic [29:0] pc, input logic [29:0] ea, input bit md,
                      input logic [29:0] pt, input logic [31:0] pte, input int d, input int fl,
                      output bit walked, output logic [29:0] waddr, output logic [29:0] ma,
                      output bit flt);
    logic [29:0] va;
    logic [19:0] vpn;
    logic [19:0] ppn;
    bit          hit;
    bit          sup;
    va  = e ? ea : pc;
    vpn = va[29:10];
    sup = 1'b0;
    req_valid = 1'b1; req_e = e; req_pc = pc; req_ea = ea; mode = md; pto = pt;
    step();
    // Scramble inputs after accept so only the latched copies can matter.
    req_valid = 1'b0; req_e = ~e; req_pc = 30'($urandom); req_ea = 30'($urandom);
    mode = ~md; pto = 30'($urandom);
    exp_ready = 1'b0;
    hit = m_lookup(vpn, ppn);
    hit = hit && md && (fl != 1);
    if (fl == 1) flush = 1'b1;
    step();
    if (fl == 1) begin flush = 1'b0; m_flush(); end
    walked = mem_req;
    waddr  = mem_addr;
    if (!md || hit) begin
      exp_resp_valid = 1'b1;
      exp_ma         = md ? {ppn, va[9:0]} : va;
      exp_fault      = 1'b0;
    end else begin
      exp_mem_req  = 1'b1;
      exp_mem_addr = pt + {10'b0, vpn};
      for (int k = 0; k < d; k++) begin
        if (fl == 2 && k == 0) flush = 1'b1;
        step();
        if (flush) begin flush = 1'b0; m_flush(); sup = 1'b1; end
      end
      mem_ack = 1'b1; mem_rdata = pte;
      if (fl == 3) flush = 1'b1;
      step();
      mem_ack = 1'b0; mem_rdata = $urandom;
      exp_mem_req    = 1'b0;
      exp_resp_valid = 1'b1;
      if (pte[0]) begin
        exp_ma    = {pte[31:12], va[9:0]};
        exp_fault = 1'b0;
        if (!sup && fl != 3) m_install(vpn, pte[31:12]);
      end else begin
        exp_ma    = va;
        exp_fault = 1'b1;
      end
      if (fl == 3) begin flush = 1'b0; m_flush(); end
    end
    ma  = resp_ma;
    flt = resp_fault;
    step();
    exp_resp_valid = 1'b0;
    exp_ready      = 1'b1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
    m_flush();
  endtask

  bit          w, f;
  logic [29:0] a, m;

  initial begin
    m_reset();
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_resp_ma", {2'b0, resp_ma}, 32'd0);
    chk("rst_mem_addr", {2'b0, mem_addr}, 32'd0);
    chk_en = 1'b1;
    step();

    // Physical mode passes the data address through.
    xact(1, 30'h3FFFFFFF, 30'h0001234, 0, 30'h0, 32'h0, 0, 0, w, a, m, f);
    chk("phys_walk", {31'b0, w}, 32'd0);
    chk("phys_ma", {2'b0, m}, 32'h0001234);

    // Miss, walk, install; then hit on the same VPN.
    xact(0, 30'h00ABCDE, 30'h0, 1, 30'h0100000, 32'h77777001, 0, 0, w, a, m, f);
    chk("miss_walk", {31'b0, w}, 32'd1);
    chk("miss_addr", {2'b0, a}, 32'h01002AF);
    chk("miss_ma", {2'b0, m}, 32'h1DDDDCDE);
    chk("miss_fault", {31'b0, f}, 32'd0);
    xact(0, 30'h00ABCDE, 30'h0, 1, 30'h0100000, 32'h0, 0, 0, w, a, m, f);
    chk("hit_walk", {31'b0, w}, 32'd0);
    chk("hit_ma", {2'b0, m}, 32'h1DDDDCDE);

    // Invalid PTE faults and is not installed.
    xact(0, 30'h0123456, 30'h0, 1, 30'h0100000, 32'h77777000, 2, 0, w, a, m, f);
    chk("fault_flag", {31'b0, f}, 32'd1);
    chk("fault_ma", {2'b0, m}, 32'h0123456);
    xact(0, 30'h0123456, 30'h0, 1, 30'h0100000, 32'h77777000, 0, 0, w, a, m, f);
    chk("fault_rewalk", {31'b0, w}, 32'd1);

    // Fill four more VPNs: the first entry (VPN 0x2AF) gets evicted.
    for (int i = 1; i <= 4; i++) begin
      xact(1, 30'h0, 30'((i << 10) | 5), 1, 30'h0200000, {20'hA0000 + 20'(i), 12'h001},
           i % 3, 0, w, a, m, f);
      chk("fill_walk", {31'b0, w}, 32'd1);
    end
    xact(0, 30'h00ABCDE, 30'h0, 1, 30'h0100000, 32'h77777001, 1, 0, w, a, m, f);
    chk("evict_rewalk", {31'b0, w}, 32'd1);
    for (int i = 2; i <= 4; i++) begin
      xact(1, 30'h0, 30'((i << 10) | 5), 1, 30'h0200000, 32'h0, 0, 0, w, a, m, f);
      chk("fill_hit", {31'b0, w}, 32'd0);
      chk("fill_hit_ma", {2'b0, m}, {2'b0, 20'hA0000 + 20'(i), 10'd5});
    end
    do_flush();
    for (int i = 2; i <= 4; i++) begin
      xact(1, 30'h0, 30'((i << 10) | 5), 1, 30'h0200000, {20'hB0000 + 20'(i), 12'h001},
           0, 0, w, a, m, f);
      chk("postflush_walk", {31'b0, w}, 32'd1);
    end
    xact(0, 30'h00ABCDE, 30'h0, 1, 30'h0100000, 32'h77777001, 0, 0, w, a, m, f);
    chk("postflush_walk_2af", {31'b0, w}, 32'd1);

    // Flush coinciding with ack: result delivered, entry not kept.
    xact(1, 30'h0, 30'h0015400, 1, 30'h0, 32'h12345001, 1, 3, w, a, m, f);
    chk("flushack_ma", {2'b0, m}, 32'h48D1400);
    xact(1, 30'h0, 30'h0015400, 1, 30'h0, 32'h12345001, 0, 0, w, a, m, f);
    chk("flushack_rewalk", {31'b0, w}, 32'd1);

    // Flush mid-walk suppresses the install.
    xact(1, 30'h0, 30'h0019800, 1, 30'h0, 32'h00ABC001, 2, 2, w, a, m, f);
    chk("flushwalk_ma", {2'b0, m}, 32'h02AF000);
    xact(1, 30'h0, 30'h0019800, 1, 30'h0, 32'h00ABC001, 0, 0, w, a, m, f);
    chk("flushwalk_rewalk", {31'b0, w}, 32'd1);

    // Flush during LOOKUP forces a miss on an installed VPN; the walk then installs.
    xact(1, 30'h0, 30'h0019800, 1, 30'h0, 32'h00ABC001, 0, 1, w, a, m, f);
    chk("flushlookup_walk", {31'b0, w}, 32'd1);
    xact(1, 30'h0, 30'h0019800, 1, 30'h0, 32'h0, 0, 0, w, a, m, f);
    chk("flushlookup_hit", {31'b0, w}, 32'd0);

    // Physical fetch path.
    xact(0, 30'h2AAAAAAA, 30'h0, 0, 30'h0, 32'h0, 0, 0, w, a, m, f);
    chk("phys_pc_ma", {2'b0, m}, 32'h2AAAAAAA);

    // PTE address wraps modulo 2^AW.
    xact(1, 30'h0, 30'h0008003, 1, 30'h3FFFFFF0, 32'h00001001, 0, 0, w, a, m, f);
    chk("wrap_addr", {2'b0, a}, 32'h0000010);
    chk("wrap_ma", {2'b0, m}, 32'h0000403);

    // mem_ack while idle must have no effect.
    mem_ack = 1'b1; mem_rdata = 32'hFFFFF001;
    step();
    mem_ack = 1'b0;
    step();

    // Reset in the middle of a walk.
    chk_en = 1'b0;
    req_valid = 1'b1; req_e = 1'b1; req_ea = 30'h001DC00; mode = 1'b1; pto = 30'h0;
    step();
    req_valid = 1'b0;
    step();
    chk("rstwalk_req_before", {31'b0, mem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstwalk_req_async", {31'b0, mem_req}, 32'd0);
    m_reset();
    for (int k = 0; k < 3; k++) begin
      mem_ack = (k == 0);
      @(negedge clk);
      chk("rstwalk_no_resp", {31'b0, resp_valid}, 32'd0);
    end
    mem_ack = 1'b0;
    step();
    rst_n = 1'b1;
    exp_ready = 1'b1; exp_mem_req = 1'b0; exp_resp_valid = 1'b0;
    exp_ma = '0; exp_fault = 1'b0;
    chk_en = 1'b1;
    step();
    xact(0, 30'h00ABCDE, 30'h0, 1, 30'h0100000, 32'h77777001, 0, 0, w, a, m, f);
    chk("rstwalk_tlb_empty", {31'b0, w}, 32'd1);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
